// File: rtl/instbuffer_queue.sv
// Circular instruction queue sitting between fetch and the dual-issue stage.
// Fetch pushes 0/1/2 instructions per cycle, issue retires 0/1/2 from the head,
// and a branch flush empties the queue. The read side is purely combinational
// from the registered state, so issue logic may use count/buses in the same cycle.
module instbuffer_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int BUS_W = 131
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_flag_i,
  input  logic             fetch_inst1_valid_i,
  input  logic             fetch_inst2_valid_i,
  input  logic [BUS_W-1:0] fetch_inst1_bus_i,
  input  logic [BUS_W-1:0] fetch_inst2_bus_i,
  output logic             buffer_allowin_o,
  input  logic [1:0]       issue_mode_i,
  output logic [1:0]       instbuffer_count_o,
  output logic [BUS_W-1:0] inst1_bus_o,
  output logic [BUS_W-1:0] inst2_bus_o,
  output logic [PTR_W:0]   occupancy_o
);

  localparam int OCC_W = PTR_W + 1;
  // Fetch may push only while at least two slots are free, so a double push
  // can never overflow regardless of how many entries issue retires.
  localparam logic [OCC_W-1:0] ALLOWIN_MAX = OCC_W'(DEPTH - 2);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [BUS_W-1:0] ram_q [DEPTH];

  logic             allowin;
  logic [1:0]       mode_eff;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic             we1;
  logic             we2;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W-1:0] head_p1;

  // Accept/retire amounts for this cycle; pop is clamped to what is queued.
  always_comb begin
    allowin  = (occ_q <= ALLOWIN_MAX);
    push_n   = 2'd0;
    if (allowin && fetch_inst1_valid_i) begin
      push_n = fetch_inst2_valid_i ? 2'd2 : 2'd1;
    end
    // Mode 11 is not a legal issue mode; retire nothing.
    mode_eff = (issue_mode_i == 2'b11) ? 2'b00 : issue_mode_i;
    if (occ_q < OCC_W'(mode_eff)) begin
      pop_n = occ_q[1:0];
    end else begin
      pop_n = mode_eff;
    end
  end

  // Next pointers/occupancy; flush overrides any push or pop in the same cycle.
  always_comb begin
    tail_p1 = tail_q + PTR_W'(1);
    head_p1 = head_q + PTR_W'(1);
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    we1     = 1'b0;
    we2     = 1'b0;
    if (branch_flag_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      we1    = (push_n != 2'd0);
      we2    = (push_n == 2'd2);
      tail_d = tail_q + PTR_W'(push_n);
      head_d = head_q + PTR_W'(pop_n);
      occ_d  = occ_q + OCC_W'(push_n) - OCC_W'(pop_n);
    end
  end

  // Queue control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Entry storage; contents are never cleared, occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (we1) begin
      ram_q[tail_q] <= fetch_inst1_bus_i;
    end
    if (we2) begin
      ram_q[tail_p1] <= fetch_inst2_bus_i;
    end
  end

  // Read side: zero-latency view of the two oldest entries.
  always_comb begin
    buffer_allowin_o   = allowin;
    occupancy_o        = occ_q;
    instbuffer_count_o = (occ_q >= OCC_W'(2)) ? 2'd2 : occ_q[1:0];
    inst1_bus_o        = (occ_q >= OCC_W'(1)) ? ram_q[head_q]  : '0;
    inst2_bus_o        = (occ_q >= OCC_W'(2)) ? ram_q[head_p1] : '0;
  end

endmodule

// File: tb/tb_instbuffer_queue.sv
module tb_instbuffer_queue;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int BUS_W = 131;

  typedef logic [BUS_W-1:0] bus_t;

  typedef struct {
    int          occ;
    logic [1:0]  cnt;
    bus_t        i1;
    bus_t        i2;
    logic        al;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             branch_flag_i;
  logic             fetch_inst1_valid_i;
  logic             fetch_inst2_valid_i;
  bus_t             fetch_inst1_bus_i;
  bus_t             fetch_inst2_bus_i;
  logic             buffer_allowin_o;
  logic [1:0]       issue_mode_i;
  logic [1:0]       instbuffer_count_o;
  bus_t             inst1_bus_o;
  bus_t             inst2_bus_o;
  logic [PTR_W:0]   occupancy_o;

  bus_t mq[$];
  exp_t expq[$];
  int   n_checks;
  int   n_pass;

  instbuffer_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .BUS_W(BUS_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .branch_flag_i       (branch_flag_i),
    .fetch_inst1_valid_i (fetch_inst1_valid_i),
    .fetch_inst2_valid_i (fetch_inst2_valid_i),
    .fetch_inst1_bus_i   (fetch_inst1_bus_i),
    .fetch_inst2_bus_i   (fetch_inst2_bus_i),
    .buffer_allowin_o    (buffer_allowin_o),
    .issue_mode_i        (issue_mode_i),
    .instbuffer_count_o  (instbuffer_count_o),
    .inst1_bus_o         (inst1_bus_o),
    .inst2_bus_o         (inst2_bus_o),
    .occupancy_o         (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input bus_t act, input bus_t req);
    n_checks++;
    if (act !== req) begin
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic bus_t rnd_bus();
    bus_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    e.occ = mq.size();
    e.cnt = (mq.size() >= 2) ? 2'd2 : 2'(mq.size());
    e.i1  = (mq.size() >= 1) ? mq[0] : '0;
    e.i2  = (mq.size() >= 2) ? mq[1] : '0;
    e.al  = ((DEPTH - mq.size()) >= 2);
    return e;
  endfunction

  // One clock of stimulus: apply inputs, advance the reference queue, and
  // hand the expected post-edge view to the monitor.
  task automatic cyc(input bit v1, input bit v2, input bus_t b1, input bus_t b2,
                     input logic [1:0] mode, input bit fl);
    int   req;
    int   pop;
    bit   allow;
    exp_t e;
    fetch_inst1_valid_i = v1;
    fetch_inst2_valid_i = v2;
    fetch_inst1_bus_i   = b1;
    fetch_inst2_bus_i   = b2;
    issue_mode_i        = mode;
    branch_flag_i       = fl;
    allow = ((DEPTH - mq.size()) >= 2);
    if (fl) begin
      mq.delete();
    end else begin
      req = (mode == 2'd3) ? 0 : int'(mode);
      pop = (req < mq.size()) ? req : mq.size();
      for (int k = 0; k < pop; k++) void'(mq.pop_front());
      if (allow && v1) begin
        mq.push_back(b1);
        if (v2) mq.push_back(b2);
      end
    end
    e = model_view();
    @(posedge clk);
    expq.push_back(e);
    #2;
  endtask

  // Monitor: after every active edge, compare DUT outputs with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("occupancy", bus_t'(occupancy_o), bus_t'(e.occ));
      chk("count", bus_t'(instbuffer_count_o), bus_t'(e.cnt));
      chk("inst1_bus", inst1_bus_o, e.i1);
      chk("inst2_bus", inst2_bus_o, e.i2);
      chk("allowin", bus_t'(buffer_allowin_o), bus_t'(e.al));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_occupancy"}, bus_t'(occupancy_o), '0);
    chk({tag, "_count"}, bus_t'(instbuffer_count_o), '0);
    chk({tag, "_inst1"}, inst1_bus_o, '0);
    chk({tag, "_inst2"}, inst2_bus_o, '0);
    chk({tag, "_allowin"}, bus_t'(buffer_allowin_o), bus_t'(1));
  endtask

  initial begin
    bus_t a;
    bus_t b;
    n_checks = 0;
    n_pass   = 0;
    rst                 = 1'b0;
    branch_flag_i       = 1'b0;
    fetch_inst1_valid_i = 1'b0;
    fetch_inst2_valid_i = 1'b0;
    fetch_inst1_bus_i   = '0;
    fetch_inst2_bus_i   = '0;
    issue_mode_i        = 2'd0;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;

    // A,B double push, then single C with SingleIssue.
    a = rnd_bus();
    b = rnd_bus();
    cyc(1, 1, a, b, 2'd0, 0);
    cyc(1, 0, rnd_bus(), rnd_bus(), 2'd1, 0);

    // Fill to DEPTH-1, attempt a rejected push, then DoubleIssue.
    cyc(0, 0, '0, '0, 2'd0, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, rnd_bus(), rnd_bus(), 2'd0, 0);
    cyc(1, 0, rnd_bus(), rnd_bus(), 2'd0, 0);
    cyc(1, 1, rnd_bus(), rnd_bus(), 2'd0, 0);
    cyc(0, 0, '0, '0, 2'd2, 0);

    // Flush at occ=5 with concurrent double push and DoubleIssue.
    cyc(0, 0, '0, '0, 2'd0, 1);
    cyc(1, 1, rnd_bus(), rnd_bus(), 2'd0, 0);
    cyc(1, 1, rnd_bus(), rnd_bus(), 2'd0, 0);
    cyc(1, 0, rnd_bus(), rnd_bus(), 2'd0, 0);
    cyc(1, 1, rnd_bus(), rnd_bus(), 2'd2, 1);

    // Over-request, illegal mode 11, slot2 without slot1.
    cyc(1, 0, rnd_bus(), rnd_bus(), 2'd0, 0);
    cyc(0, 1, rnd_bus(), rnd_bus(), 2'd3, 0);
    cyc(0, 0, '0, '0, 2'd2, 0);
    cyc(0, 0, '0, '0, 2'd1, 0);

    // Randomized traffic with one asynchronous mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cyc(1, 1, rnd_bus(), rnd_bus(), 2'd0, 0);
        cyc(1, 1, rnd_bus(), rnd_bus(), 2'd0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        mq.delete();
        #1;
        rst = 1'b1;
      end
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
          rnd_bus(), rnd_bus(), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 39) == 0));
    end

    cyc(0, 0, '0, '0, 2'd0, 0);
    @(negedge clk);
    #1;
    chk("expq_drained", bus_t'(expq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
